// File: rtl/matrix_mul_stream.sv
// Streaming matrix multiplier: C = A*B or C += A*B through one sequential MAC.
// Config, operand and result are valid/ready streams; A/B/C live in internal registers.
module matrix_mul_stream #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 40,
    parameter int MAX_M  = 8,
    parameter int MAX_K  = 8,
    parameter int MAX_N  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_valid,
    output logic                     cfg_ready,
    input  logic [$clog2(MAX_M):0]   cfg_m,
    input  logic [$clog2(MAX_K):0]   cfg_k,
    input  logic [$clog2(MAX_N):0]   cfg_n,
    input  logic                     cfg_acc,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ACC_W-1:0]         out_data,
    output logic                     out_last,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);
    localparam int MW  = $clog2(MAX_M) + 1;
    localparam int KW  = $clog2(MAX_K) + 1;
    localparam int NW  = $clog2(MAX_N) + 1;
    localparam int CW  = (MW > KW) ? ((MW > NW) ? MW : NW) : ((KW > NW) ? KW : NW);
    localparam int AAW = (MAX_M * MAX_K > 1) ? $clog2(MAX_M * MAX_K) : 1;
    localparam int BAW = (MAX_K * MAX_N > 1) ? $clog2(MAX_K * MAX_N) : 1;
    localparam int CAW = (MAX_M * MAX_N > 1) ? $clog2(MAX_M * MAX_N) : 1;

    typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, COMPUTE, DRAIN} state_t;

    typedef struct packed {
        logic [CW-1:0] m;
        logic [CW-1:0] k;
        logic [CW-1:0] n;
        logic          acc;
    } job_t;

    state_t state, state_nx;
    job_t   job;

    logic [CW-1:0]    ld_r, ld_c;
    logic [CW-1:0]    i_cnt, j_cnt, kk_cnt;
    logic [ACC_W-1:0] acc_q;
    logic             c_valid;
    logic             err_q, done_q;

    logic [DATA_W-1:0] a_mem [MAX_M*MAX_K];
    logic [DATA_W-1:0] b_mem [MAX_K*MAX_N];
    logic [ACC_W-1:0]  c_mem [MAX_M*MAX_N];

    // Handshakes and loop-end flags
    logic cfg_fire, cfg_bad, ld_fire, out_fire;
    logic [CW-1:0] lim_r, lim_c;
    logic ld_col_end, ld_last;
    logic kk_end, j_end, i_end, mac_last, drain_last;

    assign cfg_fire = cfg_valid && cfg_ready;
    assign cfg_bad  = (cfg_m == '0) || (int'(cfg_m) > MAX_M) ||
                      (cfg_k == '0) || (int'(cfg_k) > MAX_K) ||
                      (cfg_n == '0) || (int'(cfg_n) > MAX_N);
    assign ld_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    // LOAD_A walks an m x k grid, LOAD_B a k x n grid
    assign lim_r      = (state == LOAD_A) ? job.m : job.k;
    assign lim_c      = (state == LOAD_A) ? job.k : job.n;
    assign ld_col_end = (ld_c == lim_c - CW'(1));
    assign ld_last    = ld_col_end && (ld_r == lim_r - CW'(1));

    assign kk_end     = (kk_cnt == job.k - CW'(1));
    assign j_end      = (j_cnt  == job.n - CW'(1));
    assign i_end      = (i_cnt  == job.m - CW'(1));
    assign mac_last   = kk_end && j_end && i_end;
    assign drain_last = j_end && i_end;

    // Addresses: storage is laid out at MAX stride regardless of job dims
    logic [AAW-1:0] ld_a_addr, mac_a_addr;
    logic [BAW-1:0] ld_b_addr, mac_b_addr;
    logic [CAW-1:0] c_addr;

    assign ld_a_addr  = AAW'(int'(ld_r)  * MAX_K + int'(ld_c));
    assign ld_b_addr  = BAW'(int'(ld_r)  * MAX_N + int'(ld_c));
    assign mac_a_addr = AAW'(int'(i_cnt) * MAX_K + int'(kk_cnt));
    assign mac_b_addr = BAW'(int'(kk_cnt) * MAX_N + int'(j_cnt));
    assign c_addr     = CAW'(int'(i_cnt) * MAX_N + int'(j_cnt));

    // MAC datapath
    logic signed [DATA_W-1:0]   a_op, b_op;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    prod_ext;
    logic [ACC_W-1:0]           mac_base, mac_sum;

    assign a_op     = a_mem[mac_a_addr];
    assign b_op     = b_mem[mac_b_addr];
    assign prod     = a_op * b_op;
    assign prod_ext = ACC_W'(prod);

    always_comb begin
        mac_base = acc_q;
        if (kk_cnt == '0)
            mac_base = (job.acc && c_valid) ? c_mem[c_addr] : '0;
        mac_sum = mac_base + prod_ext;
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // FSM next state
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (cfg_fire && !cfg_bad)   state_nx = LOAD_A;
            LOAD_A:  if (ld_fire && ld_last)     state_nx = LOAD_B;
            LOAD_B:  if (ld_fire && ld_last)     state_nx = COMPUTE;
            COMPUTE: if (mac_last)               state_nx = DRAIN;
            DRAIN:   if (out_fire && drain_last) state_nx = IDLE;
            default:                             state_nx = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        cfg_ready = (state == IDLE);
        in_ready  = (state == LOAD_A) || (state == LOAD_B);
        out_valid = (state == DRAIN);
        out_last  = (state == DRAIN) && drain_last;
        out_data  = (state == DRAIN) ? c_mem[c_addr] : '0;
        busy      = (state != IDLE);
    end

    assign done = done_q;
    assign err  = err_q;

    // Counters, job latch and status flags
    always_ff @(posedge clk) begin
        if (rst) begin
            job     <= '0;
            ld_r    <= '0;
            ld_c    <= '0;
            i_cnt   <= '0;
            j_cnt   <= '0;
            kk_cnt  <= '0;
            acc_q   <= '0;
            c_valid <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: if (cfg_fire) begin
                    job.m   <= CW'(cfg_m);
                    job.k   <= CW'(cfg_k);
                    job.n   <= CW'(cfg_n);
                    job.acc <= cfg_acc;
                    err_q   <= cfg_bad;
                    ld_r    <= '0;
                    ld_c    <= '0;
                    i_cnt   <= '0;
                    j_cnt   <= '0;
                    kk_cnt  <= '0;
                end
                LOAD_A, LOAD_B: if (ld_fire) begin
                    if (ld_col_end) begin
                        ld_c <= '0;
                        ld_r <= ld_last ? '0 : ld_r + CW'(1);
                    end else begin
                        ld_c <= ld_c + CW'(1);
                    end
                end
                COMPUTE: begin
                    acc_q <= mac_sum;
                    if (kk_end) begin
                        kk_cnt <= '0;
                        if (j_end) begin
                            j_cnt <= '0;
                            i_cnt <= i_end ? '0 : i_cnt + CW'(1);
                        end else begin
                            j_cnt <= j_cnt + CW'(1);
                        end
                    end else begin
                        kk_cnt <= kk_cnt + CW'(1);
                    end
                    if (mac_last) c_valid <= 1'b1;
                end
                // i/j are reused as the drain read pointer
                DRAIN: if (out_fire) begin
                    if (j_end) begin
                        j_cnt <= '0;
                        i_cnt <= i_end ? '0 : i_cnt + CW'(1);
                    end else begin
                        j_cnt <= j_cnt + CW'(1);
                    end
                    if (drain_last) done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Operand and result storage, no reset needed on contents
    always_ff @(posedge clk) begin
        if (!rst && state == LOAD_A && ld_fire) a_mem[ld_a_addr] <= in_data;
        if (!rst && state == LOAD_B && ld_fire) b_mem[ld_b_addr] <= in_data;
        if (!rst && state == COMPUTE && kk_end) c_mem[c_addr]    <= mac_sum;
    end

endmodule

// File: tb/tb_matrix_mul_stream.sv
// Directed bench for matrix_mul_stream: basic, accumulate, backpressure,
// dimension errors, signed/max-size and mid-job reset scenarios.
module tb_matrix_mul_stream;
    localparam int DATA_W = 16;
    localparam int ACC_W  = 40;
    localparam int MAX_M  = 8;
    localparam int MAX_K  = 8;
    localparam int MAX_N  = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cfg_valid = 1'b0, cfg_ready, cfg_acc = 1'b0;
    logic [3:0]        cfg_m = '0, cfg_k = '0, cfg_n = '0;
    logic              in_valid = 1'b0, in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic              out_valid, out_ready = 1'b1, out_last;
    logic [ACC_W-1:0]  out_data;
    logic              busy, done, err;

    matrix_mul_stream #(
        .DATA_W(DATA_W), .ACC_W(ACC_W), .MAX_M(MAX_M), .MAX_K(MAX_K), .MAX_N(MAX_N)
    ) dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_m(cfg_m), .cfg_k(cfg_k), .cfg_n(cfg_n), .cfg_acc(cfg_acc),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [ACC_W-1:0] got [64];
    logic             got_last [64];
    int               got_cnt, unstable, compute_cyc;
    logic             done_ok;

    // All driver tasks start and end on a falling edge.
    task automatic send_cfg(input int m, input int k, input int n, input logic acc);
        int w = 0;
        cfg_valid = 1'b1; cfg_m = 4'(m); cfg_k = 4'(k); cfg_n = 4'(n); cfg_acc = acc;
        while (!cfg_ready && w < 2000) begin @(negedge clk); w++; end
        if (!cfg_ready) begin
            checks++; failures++;
            $display("FAIL cfg_timeout cfg_ready=%0b required=1", cfg_ready);
        end
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    task automatic send_word(input logic [DATA_W-1:0] d, input int gap);
        int w = 0;
        repeat (gap) @(negedge clk);
        in_valid = 1'b1; in_data = d;
        while (!in_ready && w < 2000) begin @(negedge clk); w++; end
        if (!in_ready) begin
            checks++; failures++;
            $display("FAIL in_timeout in_ready=%0b required=1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_words(input logic [DATA_W-1:0] a[$], input logic [DATA_W-1:0] b[$],
                              input int max_gap);
        foreach (a[i]) send_word(a[i], (max_gap > 0) ? $urandom_range(0, max_gap) : 0);
        foreach (b[i]) send_word(b[i], (max_gap > 0) ? $urandom_range(0, max_gap) : 0);
    endtask

    task automatic collect(input int n, input logic rnd);
        int   w = 0;
        logic held_v = 1'b0;
        logic [ACC_W-1:0] held_d = '0;
        got_cnt = 0; unstable = 0; compute_cyc = 0;
        while (got_cnt < n && w < 4000) begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (held_v && (!out_valid || out_data !== held_d)) unstable++;
            if (busy && !out_valid && !in_ready && got_cnt == 0) compute_cyc++;
            if (out_valid && out_ready) begin
                got[got_cnt] = out_data; got_last[got_cnt] = out_last;
                got_cnt++; held_v = 1'b0;
            end else if (out_valid) begin
                held_v = 1'b1; held_d = out_data;
            end
            @(negedge clk); w++;
        end
        if (got_cnt < n) begin
            checks++; failures++;
            $display("FAIL out_timeout words=%0d required=%0d", got_cnt, n);
        end
        done_ok   = done && !busy && cfg_ready && !out_valid;
        out_ready = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk); @(negedge clk);
        checks++;
        if ({cfg_ready, in_ready, out_valid, out_last, busy, done, err} !== 7'b1000000) begin
            failures++;
            $display("FAIL reset_flags got=%b required=1000000",
                     {cfg_ready, in_ready, out_valid, out_last, busy, done, err});
        end
        checks++;
        if (out_data !== '0) begin
            failures++; $display("FAIL reset_out_data got=%0h required=0", out_data);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [DATA_W-1:0] qa[$] = '{1, 2, 3, 4, 5, 6};
        logic [DATA_W-1:0] qb[$] = '{7, 8, 9, 10, 11, 12};
        logic [ACC_W-1:0]  e[4]  = '{58, 64, 139, 154};
        send_cfg(2, 3, 2, 1'b0);
        send_words(qa, qb, 0);
        collect(4, 1'b0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got[i] !== e[i] || got_last[i] !== (i == 3)) begin
                failures++;
                $display("FAIL basic_word%0d got=%0d last=%0b required=%0d last=%0b",
                         i, got[i], got_last[i], e[i], (i == 3));
            end
        end
        checks++;
        if (done_ok !== 1'b1) begin failures++; $display("FAIL basic_done got=%0b required=1", done_ok); end
        checks++;
        if (compute_cyc != 12) begin
            failures++; $display("FAIL basic_compute_cycles got=%0d required=12", compute_cyc);
        end
    endtask

    task automatic test_accumulate();
        logic [DATA_W-1:0] qa[$] = '{1, 2, 3, 4, 5, 6};
        logic [DATA_W-1:0] qb[$] = '{7, 8, 9, 10, 11, 12};
        logic [ACC_W-1:0]  e2[4] = '{116, 128, 278, 308};
        logic [ACC_W-1:0]  e1[4] = '{58, 64, 139, 154};
        send_cfg(2, 3, 2, 1'b1);
        send_words(qa, qb, 0);
        collect(4, 1'b0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got[i] !== e2[i]) begin
                failures++; $display("FAIL acc_word%0d got=%0d required=%0d", i, got[i], e2[i]);
            end
        end
        do_reset();
        send_cfg(2, 3, 2, 1'b1);
        send_words(qa, qb, 0);
        collect(4, 1'b0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got[i] !== e1[i]) begin
                failures++; $display("FAIL acc_after_reset_word%0d got=%0d required=%0d", i, got[i], e1[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [DATA_W-1:0] qa[$] = '{1, 2, 3, 4, 5, 6};
        logic [DATA_W-1:0] qb[$] = '{7, 8, 9, 10, 11, 12};
        logic [ACC_W-1:0]  e[4]  = '{58, 64, 139, 154};
        send_cfg(2, 3, 2, 1'b0);
        send_words(qa, qb, 2);
        collect(4, 1'b1);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got[i] !== e[i] || got_last[i] !== (i == 3)) begin
                failures++;
                $display("FAIL bp_word%0d got=%0d last=%0b required=%0d last=%0b",
                         i, got[i], got_last[i], e[i], (i == 3));
            end
        end
        checks++;
        if (unstable != 0) begin failures++; $display("FAIL bp_stall_stable got=%0d required=0", unstable); end
        checks++;
        if (done_ok !== 1'b1) begin failures++; $display("FAIL bp_done got=%0b required=1", done_ok); end
    endtask

    task automatic test_dim_error();
        send_cfg(0, 3, 2, 1'b0);
        checks++;
        if ({err, busy, in_ready} !== 3'b100) begin
            failures++; $display("FAIL dim_m0 err_busy_inrdy=%b required=100", {err, busy, in_ready});
        end
        @(negedge clk);
        send_cfg(MAX_M + 1, 1, 1, 1'b0);
        checks++;
        if ({err, busy, cfg_ready} !== 3'b101) begin
            failures++; $display("FAIL dim_mmax err_busy_cfgrdy=%b required=101", {err, busy, cfg_ready});
        end
    endtask

    task automatic test_signed_max();
        logic [DATA_W-1:0] qa[$] = '{16'hFFFD};
        logic [DATA_W-1:0] qb[$] = '{16'd5};
        logic [DATA_W-1:0] fa[$];
        logic [ACC_W-1:0]  neg15 = 40'hFF_FFFF_FFF1;
        logic [ACC_W-1:0]  cmax  = 40'h01_FFF8_0008;
        int bad = 0, bad_last = 0;
        send_cfg(1, 1, 1, 1'b0);
        checks++;
        if ({err, busy} !== 2'b01) begin failures++; $display("FAIL dim_err_clear err_busy=%b required=01", {err, busy}); end
        send_words(qa, qb, 0);
        collect(1, 1'b0);
        checks++;
        if (got[0] !== neg15 || got_last[0] !== 1'b1) begin
            failures++; $display("FAIL signed_1x1 got=%0h last=%0b required=%0h last=1", got[0], got_last[0], neg15);
        end
        for (int i = 0; i < MAX_M * MAX_K; i++) fa.push_back(16'h7FFF);
        send_cfg(MAX_M, MAX_K, MAX_N, 1'b0);
        send_words(fa, fa, 0);
        collect(MAX_M * MAX_N, 1'b0);
        for (int i = 0; i < MAX_M * MAX_N; i++) begin
            if (got[i] !== cmax) bad++;
            if (got_last[i] !== (i == MAX_M * MAX_N - 1)) bad_last++;
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL max_values wrong=%0d required=0 first=%0h", bad, got[0]); end
        checks++;
        if (bad_last != 0) begin failures++; $display("FAIL max_last wrong=%0d required=0", bad_last); end
        checks++;
        if (compute_cyc != MAX_M * MAX_N * MAX_K) begin
            failures++; $display("FAIL max_compute_cycles got=%0d required=%0d", compute_cyc, MAX_M * MAX_N * MAX_K);
        end
    endtask

    task automatic test_reset_midop();
        logic [DATA_W-1:0] qa[$] = '{1, 2, 3, 4, 5, 6};
        logic [DATA_W-1:0] qb[$] = '{7, 8, 9};
        logic [DATA_W-1:0] qbf[$] = '{7, 8, 9, 10, 11, 12};
        logic [ACC_W-1:0]  e[4]  = '{58, 64, 139, 154};
        send_cfg(2, 3, 2, 1'b0);
        send_words(qa, qb, 0);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({cfg_ready, in_ready, out_valid, out_last, busy, done, err} !== 7'b1000000 || out_data !== '0) begin
            failures++;
            $display("FAIL rst_in_load_b flags=%b data=%0h required=1000000 data=0",
                     {cfg_ready, in_ready, out_valid, out_last, busy, done, err}, out_data);
        end
        rst = 1'b0;
        @(negedge clk);
        send_cfg(2, 3, 2, 1'b0);
        send_words(qa, qbf, 0);
        collect(2, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({cfg_ready, in_ready, out_valid, out_last, busy, done, err} !== 7'b1000000 || out_data !== '0) begin
            failures++;
            $display("FAIL rst_in_drain flags=%b data=%0h required=1000000 data=0",
                     {cfg_ready, in_ready, out_valid, out_last, busy, done, err}, out_data);
        end
        rst = 1'b0;
        @(negedge clk);
        send_cfg(2, 3, 2, 1'b0);
        send_words(qa, qbf, 0);
        collect(4, 1'b0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got[i] !== e[i]) begin
                failures++; $display("FAIL post_reset_word%0d got=%0d required=%0d", i, got[i], e[i]);
            end
        end
        checks++;
        if (done_ok !== 1'b1) begin failures++; $display("FAIL post_reset_done got=%0b required=1", done_ok); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_accumulate();
        test_backpressure();
        test_dim_error();
        test_signed_max();
        test_reset_midop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/matrix_mul_stream.md
Name: matrix_mul_stream

Overview:
Next-generation matrix multiply top: computes C = A x B, or C = C + A x B in accumulate mode, with runtime dimensions up to parametrised maxima.
- Replaces the fixed 32-bit serial-mode-select interface with three valid/ready streams: config, operand in and result out.
- Adds output backpressure, dimension checking with an error flag, and C-accumulate across jobs.
- Contains a sequential single-MAC engine with internal A/B/C storage, between the host-side serializer and any downstream consumer.

Parameters:
DATA_W, 16, operand width (signed two's complement)
ACC_W, 40, accumulator and result width (signed; must be >= 2*DATA_W)
MAX_M, 8, max rows of A/C
MAX_K, 8, max cols of A / rows of B
MAX_N, 8, max cols of B/C

Ports:
clk  in  1  clock, all logic rising-edge
rst  in  1  synchronous, active-high reset
cfg_valid  in  1  job descriptor valid
cfg_ready  out  1  descriptor accepted when cfg_valid&&cfg_ready
cfg_m  in  clog2(MAX_M)+1  M for job
cfg_k  in  clog2(MAX_K)+1  K for job
cfg_n  in  clog2(MAX_N)+1  N for job
cfg_acc  in  1  1: C += A*B; 0: C = A*B
in_valid  in  1  operand word valid
in_ready  out  1  operand accepted when in_valid&&in_ready
in_data  in  DATA_W  operand word
out_valid  out  1  result word valid
out_ready  in  1  consumer ready
out_data  out  ACC_W  result word
out_last  out  1  marks final C word (with out_valid)
busy  out  1  high in any state but IDLE
done  out  1  one-cycle pulse at job end
err  out  1  sticky: last descriptor rejected

Behaviour:
- Reset (sync, rst=1): state IDLE. Output values: cfg_ready=1, in_ready=0, out_valid=0, out_last=0, out_data=0, busy=0, done=0, err=0. Internal c_valid cleared. Reset mid-job aborts immediately; no partial output continues.
- FSM: IDLE -> LOAD_A -> LOAD_B -> COMPUTE -> DRAIN -> IDLE.
- IDLE: cfg_ready=1; in_valid ignored.
  - On descriptor handshake, latch m, k, n and acc.
  - If any dim is 0 or exceeds its MAX, set err=1 and stay IDLE.
  - Otherwise clear err and go to LOAD_A next cycle.
- LOAD_A: in_ready=1. Accepts exactly m*k words, row-major, A[i][kk] at index i*MAX_K+kk. Goes to LOAD_B the cycle after the last accepted word. Gaps in in_valid are allowed.
- LOAD_B: in_ready=1. Accepts exactly k*n words, row-major, into B. Goes to COMPUTE after the last word.
- cfg_ready=0 in every state except IDLE. Descriptors offered while busy are not consumed.
- COMPUTE: one MAC per cycle. Loop order is i outer, j, then kk inner.
  - At kk=0 the accumulator starts at C[i][j] if (acc && c_valid), else 0.
  - Product is sign-extended to ACC_W. Sum wraps modulo 2^ACC_W with no saturation.
  - At kk=k-1, C[i][j] is written in the same cycle.
  - Takes exactly m*n*k cycles; DRAIN is entered the next cycle and c_valid is set.
- c_valid: cleared by rst only. acc=1 on the first job after reset behaves as acc=0.
- Accumulate mode with different m/n than the prior job uses C storage as addressed (i*MAX_N+j) and is legal.
- DRAIN: streams C row-major, m*n words.
  - out_valid is held and out_data is stable while out_ready=0.
  - A word advances only on handshake. One word per cycle is sustained when out_ready=1.
  - out_last=1 only with the final word.
- done pulses 1 in the cycle after the final output handshake. In that same cycle state=IDLE, busy=0 and cfg_ready=1.
- Simultaneous cfg_valid and done: descriptor may be accepted in the done cycle (cfg_ready=1).
- Storage is registers or inferred RAM with no reset requirement on A/B/C contents.

Test Plan:
- Basic: cfg 2x3x2, acc=0, A=[1,2,3,4,5,6], B=[7,8,9,10,11,12], out_ready=1 -> out 58,64,139,154; out_last on 154; done pulse next cycle; compute phase 12 cycles.
- Accumulate: repeat the same A/B with acc=1 -> 116,128,278,308. Then rst, then acc=1 job -> 58,64,139,154 (c_valid cleared).
- Backpressure + gaps: random in_valid gaps and out_ready toggling 50% on the basic job -> identical 4 values in order; out_data stable while stalled; no duplicate or lost words.
- Dimension error: cfg m=0 -> err=1, busy stays 0, in_ready=0. Cfg m=MAX_M+1 -> err=1. Valid cfg 1x1x1 -> err clears.
- Signed + max size: 1x1x1 with A=-3, B=5 -> out_data=-15 sign-extended to ACC_W. Job MAX_M x MAX_K x MAX_N with all operands 0x7FFF -> every C = MAX_K*0x3FFF0001.
- Reset mid-op: assert rst during LOAD_B and during DRAIN -> next cycle all outputs at reset values. A fresh basic job then passes.
